// File: rtl/store_unit_pkg.sv
// store_unit_pkg: shared CPU load/store widths and store FSM state encoding
package store_unit_pkg;
  localparam int ADDR_W_DEF = 12;
  localparam int WORD_W_DEF = 16;
  typedef logic [2:0] state_t;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LD_MAR = 3'd1;
  localparam logic [2:0] S_LD_MBR = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_FIN    = 3'd4;
endpackage

// File: rtl/store_unit.sv
// store_unit: stores AC to memory address X via MAR/MBR with an ack timeout
module store_unit
  import store_unit_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int WORD_W      = WORD_W_DEF,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] X,
  input  logic [WORD_W-1:0] AC,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] xl_q, xl_d, mar_q, mar_d;
  logic [WORD_W-1:0] al_q, al_d, mbr_q, mbr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  always_comb begin
    state_d = state_q;
    xl_d = xl_q;
    al_d = al_q;
    mar_d = mar_q;
    mbr_d = mbr_q;
    cnt_d = cnt_q;
    err_d = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        xl_d = X;
        al_d = AC;
        state_d = S_LD_MAR;
      end
      S_LD_MAR: begin
        mar_d = xl_q;
        state_d = S_LD_MBR;
      end
      S_LD_MBR: begin
        mbr_d = al_q;
        cnt_d = '0;
        state_d = S_WRITE;
      end
      // ack wins over timeout in the final wait cycle
      S_WRITE: if (mem_ack) state_d = S_FIN;
        else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
          state_d = S_IDLE;
          err_d = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      xl_q <= '0;
      al_q <= '0;
      mar_q <= '0;
      mbr_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      xl_q <= xl_d;
      al_q <= al_d;
      mar_q <= mar_d;
      mbr_q <= mbr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign mem_addr = mar_q;
  assign mem_wdata = mbr_q;
  assign mem_we = state_q == S_WRITE;
  assign busy = state_q != S_IDLE;
  assign done = state_q == S_FIN;
  assign err = err_q;
endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: directed store sequences checked against a write scoreboard
module tb_store_unit;
  localparam int AT = 15;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, mem_ack = 1'b0;
  logic [11:0] X = '0, mem_addr;
  logic [15:0] AC = '0, mem_wdata;
  logic mem_we, busy, done, err;
  int checks = 0, failures = 0;
  logic [27:0] exp_q[$];
  logic [27:0] e;
  logic prev_we = 1'b0;
  logic [11:0] prev_addr = '0;
  logic [15:0] prev_data = '0;

  store_unit #(.ADDR_W(12), .WORD_W(16), .ACK_TIMEOUT(AT)) dut (
    .clk(clk), .rst(rst), .start(start), .X(X), .AC(AC),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_ack(mem_ack), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // accepted memory writes are popped and compared against the queued store
  always @(negedge clk) begin
    if (mem_we === 1'b1 && mem_ack === 1'b1 && rst === 1'b0) begin
      if (exp_q.size() == 0) chk("sb_unexpected_write", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("sb_addr", {20'd0, mem_addr}, {20'd0, e[27:16]});
        chk("sb_data", {16'd0, mem_wdata}, {16'd0, e[15:0]});
      end
    end
    if (mem_we === 1'b1 && prev_we) begin
      chk("we_addr_stable", {20'd0, mem_addr}, {20'd0, prev_addr});
      chk("we_data_stable", {16'd0, mem_wdata}, {16'd0, prev_data});
    end
    if (done === 1'b1 || err === 1'b1) chk("done_err_excl", {31'd0, done & err}, 32'd0);
    prev_we = mem_we === 1'b1;
    prev_addr = mem_addr;
    prev_data = mem_wdata;
  end

  // delay < 0: never ack; inject: issue a competing start during WRITE
  task automatic run_store(input logic [11:0] x, input logic [15:0] ac, input int delay, input bit inject);
    int we_cycles = 0;
    bit ok = delay >= 0;
    X = x;
    AC = ac;
    start = 1'b1;
    if (ok) exp_q.push_back({x, ac});
    tick;
    start = 1'b0;
    chk("ldmar_busy", {31'd0, busy}, 32'd1);
    chk("ldmar_we", {31'd0, mem_we}, 32'd0);
    tick;
    chk("ldmbr_we", {31'd0, mem_we}, 32'd0);
    tick;
    chk("write_addr", {20'd0, mem_addr}, {20'd0, x});
    chk("write_data", {16'd0, mem_wdata}, {16'd0, ac});
    for (int i = 0; i < 40; i++) begin
      if (mem_we !== 1'b1) break;
      we_cycles++;
      mem_ack = ok && i == delay;
      if (inject && i == 1) begin
        X = 12'hFFF;
        AC = 16'hBEEF;
        start = 1'b1;
      end
      tick;
      mem_ack = 1'b0;
      start = 1'b0;
    end
    chk("we_cycles", we_cycles, ok ? delay + 1 : AT);
    chk("end_done", {31'd0, done}, {31'd0, ok});
    chk("end_err", {31'd0, err}, {31'd0, !ok});
    chk("end_busy", {31'd0, busy}, {31'd0, ok});
    tick;
    chk("after_done", {31'd0, done}, 32'd0);
    chk("after_err", {31'd0, err}, 32'd0);
    chk("after_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b1;
    mem_ack = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    start = 1'b0;
    mem_ack = 1'b0;
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_addr", {20'd0, mem_addr}, 32'd0);
    chk("rst_data", {16'd0, mem_wdata}, 32'd0);
    run_store(12'h0A5, 16'h1234, 0, 1'b0);
    run_store(12'h0A5, 16'h1234, 5, 1'b0);
    run_store(12'h123, 16'h0F0F, -1, 1'b0);
    run_store(12'h0A5, 16'h1234, 3, 1'b1);
    run_store(12'hFFF, 16'hBEEF, 0, 1'b0);
    run_store(12'h555, 16'hAAAA, AT - 1, 1'b0);
    X = 12'h321;
    AC = 16'h4567;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    chk("rstw_we_before", {31'd0, mem_we}, 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rstw_we", {31'd0, mem_we}, 32'd0);
    chk("rstw_mar", {20'd0, mem_addr}, 32'd0);
    chk("rstw_mbr", {16'd0, mem_wdata}, 32'd0);
    chk("rstw_busy", {31'd0, busy}, 32'd0);
    chk("rstw_done", {31'd0, done}, 32'd0);
    chk("rstw_err", {31'd0, err}, 32'd0);
    tick;
    chk("rstw_done2", {31'd0, done}, 32'd0);
    chk("rstw_err2", {31'd0, err}, 32'd0);
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    chk("idle_ack_busy", {31'd0, busy}, 32'd0);
    chk("idle_ack_done", {31'd0, done}, 32'd0);
    chk("idle_ack_we", {31'd0, mem_we}, 32'd0);
    run_store(12'h001, 16'h0001, 0, 1'b0);
    tick;
    chk("sb_drain", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/store_unit.md
STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 Parameter ADDR_W, default 12, memory address width (4096 words).
REQ-002 Parameter WORD_W, default 16, data word width.
REQ-003 Parameter ACK_TIMEOUT, default 15, maximum cycles to wait for mem_ack before aborting.
REQ-004 clk  in  1  sole clock; all state SHALL update on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  one-cycle request to store AC to address X; ignored while busy.
REQ-007 X  in  ADDR_W  target address, sampled on accepted start.
REQ-008 AC  in  WORD_W  accumulator value, sampled on accepted start.
REQ-009 mem_addr  out  ADDR_W  write address to memory, driven from MAR.
REQ-010 mem_wdata  out  WORD_W  write data to memory, driven from MBR.
REQ-011 mem_we  out  1  write strobe, held high until ack or timeout.
REQ-012 mem_ack  in  1  memory write acknowledge, valid only while mem_we high.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 done  out  1  one-cycle pulse on successful completion.
REQ-015 err  out  1  one-cycle pulse on ack timeout.

Function
REQ-016 FSM states: IDLE, LD_MAR, LD_MBR, WRITE, FIN.
REQ-017 IDLE: start=1 -> capture X into an internal address latch and AC into a data latch; go to LD_MAR next cycle.
REQ-018 LD_MAR: MAR <= latched X; go to LD_MBR.
REQ-019 LD_MBR: MBR <= latched AC; go to WRITE.
REQ-020 WRITE: mem_we=1, mem_addr=MAR, mem_wdata=MBR; mem_ack=1 -> go to FIN; else increment wait counter.
REQ-021 Wait counter reaching ACK_TIMEOUT without ack -> drop mem_we, pulse err, return to IDLE; MAR/MBR keep their values.
REQ-022 FIN: done=1 for exactly one cycle; go to IDLE.
REQ-023 Latency start->done with immediate ack SHALL be 4 cycles (start at cycle 0, mem_we high at cycle 3, done at cycle 4).
REQ-024 mem_ack arriving in the same cycle the counter reaches ACK_TIMEOUT SHALL count as success (done, not err).
REQ-025 mem_ack outside WRITE SHALL be ignored.
REQ-026 start while busy SHALL be ignored and SHALL NOT change the latches.
REQ-027 start in the cycle after done or err SHALL be accepted (back-to-back stores).
REQ-028 mem_we SHALL be low in every state except WRITE; mem_addr/mem_wdata SHALL be stable throughout WRITE.
REQ-029 Wait counter SHALL be cleared on entry to WRITE; width SHALL be sufficient for ACK_TIMEOUT with no wrap.
REQ-030 done and err SHALL never be high in the same cycle.

Reset
REQ-031 rst=1 SHALL force IDLE and clear MAR, MBR, latches and wait counter to 0 on the next edge.
REQ-032 Outputs after reset: mem_we=0, busy=0, done=0, err=0, mem_addr=0, mem_wdata=0.
REQ-033 rst mid-operation (including during WRITE) SHALL abort without a done or err pulse; mem_we SHALL be low the cycle after reset.
REQ-034 rst SHALL take priority over start and mem_ack.

Structure
REQ-035 State encoding, ADDR_W and WORD_W defaults SHALL live in the shared CPU package used by the load/store operations.
REQ-036 The block SHALL be a single module; the timeout counter is inline, no sub-module.

Verification
REQ-037 Reset then start with X=0x0A5, AC=0x1234, mem_ack high at first WRITE cycle -> mem_we high cycle 3 with mem_addr=0x0A5, mem_wdata=0x1234; done cycle 4.
REQ-038 Same store with mem_ack delayed 5 cycles -> mem_we held 6 cycles, addr/data stable, done the cycle after ack.
REQ-039 mem_ack never asserted -> mem_we high ACK_TIMEOUT cycles, err pulse once, busy low afterward, no done.
REQ-040 Second start (X=0xFFF, AC=0xBEEF) during WRITE of first store -> first completes unchanged; second ignored; then start right after done with X=0xFFF, AC=0xBEEF -> accepted, written to 0xFFF.
REQ-041 rst asserted during WRITE -> mem_we low next cycle, MAR=MBR=0, no done/err pulse.
REQ-042 mem_ack pulsed while IDLE -> no state change, no done.
